// File: rtl/counter_dump.sv
// rtl/counter_dump.sv - snapshot two event counters and stream them as a checksummed byte frame
module counter_dump #(
    parameter int         CNT_W  = 64,
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Snap,
    input  logic [CNT_W-1:0] Cnt0,
    input  logic [CNT_W-1:0] Cnt1,
    output logic [7:0]       Dout,
    output logic             Dvalid,
    input  logic             Dready,
    output logic             Dlast,
    output logic             Busy,
    output logic             Drop
);

    localparam int NB = 2 * CNT_W / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        SUM  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [2*CNT_W-1:0]   shadow_q, shadow_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [7:0]           chk_q, chk_d;
    logic [7:0]           dout_q, dout_d;
    logic                 dvalid_q, dvalid_d;
    logic                 dlast_q, dlast_d;
    logic                 drop_q, drop_d;

    logic                 xfer;

    // A byte moves whenever the presented byte is accepted by the sink
    assign xfer = dvalid_q & Dready;

    // State and datapath registers; reset aborts any frame immediately
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            chk_q    <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            dlast_q  <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            chk_q    <= chk_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            dlast_q  <= dlast_d;
            drop_q   <= drop_d;
        end
    end

    // Next-state: advance only on accepted transfers, leave IDLE only on Snap
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (Snap) state_d = HDR;
            HDR:  if (xfer) state_d = DATA;
            DATA: if (xfer && idx_q == LAST_IDX) state_d = SUM;
            SUM:  if (xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs; the shadow shifts left so the
    // byte to send next is always its top byte (Cnt0 MSB first, then Cnt1)
    always_comb begin
        shadow_d = shadow_q;
        idx_d    = idx_q;
        chk_d    = chk_q;
        dout_d   = dout_q;
        dvalid_d = dvalid_q;
        dlast_d  = dlast_q;
        drop_d   = Snap && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (Snap) begin
                    shadow_d = {Cnt0, Cnt1};
                    idx_d    = '0;
                    chk_d    = '0;
                    dout_d   = HEADER;
                    dvalid_d = 1'b1;
                    dlast_d  = 1'b0;
                end
            end
            HDR: begin
                if (xfer) begin
                    idx_d  = '0;
                    dout_d = shadow_q[2*CNT_W-1 -: 8];
                end
            end
            DATA: begin
                if (xfer) begin
                    chk_d    = chk_q ^ dout_q;
                    shadow_d = shadow_q << 8;
                    idx_d    = idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        dout_d  = chk_q ^ dout_q;
                        dlast_d = 1'b1;
                    end else begin
                        dout_d = shadow_q[2*CNT_W-9 -: 8];
                    end
                end
            end
            SUM: begin
                if (xfer) begin
                    dout_d   = '0;
                    dvalid_d = 1'b0;
                    dlast_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign Dout   = dout_q;
    assign Dvalid = dvalid_q;
    assign Dlast  = dlast_q;
    assign Busy   = (state_q != IDLE);
    assign Drop   = drop_q;

endmodule

// File: tb/tb_counter_dump.sv
// tb/tb_counter_dump.sv - scoreboard bench for counter_dump with a frame-level reference model
module tb_counter_dump;

    localparam int N = 18;

    logic        Clk;
    logic        Reset;
    logic        Snap;
    logic [63:0] Cnt0;
    logic [63:0] Cnt1;
    logic [7:0]  Dout;
    logic        Dvalid;
    logic        Dready;
    logic        Dlast;
    logic        Busy;
    logic        Drop;

    counter_dump dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Snap  (Snap),
        .Cnt0  (Cnt0),
        .Cnt1  (Cnt1),
        .Dout  (Dout),
        .Dvalid(Dvalid),
        .Dready(Dready),
        .Dlast (Dlast),
        .Busy  (Busy),
        .Drop  (Drop)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_vec  = 0;
    int n_fail = 0;

    // expected bytes of frames in flight: {last, byte}
    logic [8:0] exp_q[$];

    // frame-level model: is a frame open, how many bytes remain, drop pending
    bit m_active = 0;
    int m_rem    = 0;
    bit m_drop   = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push_frame(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] both;
        logic [7:0]   d;
        logic [7:0]   chk;
        both = {a, b};
        chk  = 8'h00;
        exp_q.push_back({1'b0, 8'hA5});
        for (int i = 0; i < 16; i++) begin
            d = 8'((both >> (8 * (15 - i))) & 128'hFF);
            chk = chk ^ d;
            exp_q.push_back({1'b0, d});
        end
        exp_q.push_back({1'b1, chk});
    endfunction

    // one clock: check Busy/Drop after the edge, then apply inputs for the next edge
    task automatic step(input logic s, input logic r, input logic [63:0] a, input logic [63:0] b);
        bit was_active;
        @(posedge Clk);
        #1;
        check("busy", Busy, m_active);
        check("drop", Drop, m_drop);
        Snap  = s;
        Dready = r;
        Cnt0  = a;
        Cnt1  = b;
        was_active = m_active;
        m_drop = s && was_active;
        if (was_active && r) begin
            m_rem--;
            if (m_rem == 0) m_active = 0;
        end
        if (s && !was_active) begin
            push_frame(a, b);
            m_active = 1;
            m_rem    = N;
        end
    endtask

    task automatic drain(input int max_cycles);
        int k;
        k = 0;
        while (m_active && k < max_cycles) begin
            step(1'b0, 1'b1, 64'h0, 64'h0);
            k++;
        end
        check("drain_timeout", m_active, 1'b0);
        step(1'b0, 1'b1, 64'h0, 64'h0);
        step(1'b0, 1'b1, 64'h0, 64'h0);
        check("queue_empty", exp_q.size(), 0);
    endtask

    // monitor: compare the presented byte with the scoreboard head, pop on transfer
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge Clk);
            if (Reset && Dvalid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", Dvalid, 1'b0);
                end else begin
                    e = exp_q[0];
                    check("dout", Dout, e[7:0]);
                    check("dlast", Dlast, e[8]);
                    if (Dready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [63:0] c0;
        Reset  = 1'b0;
        Snap   = 1'b0;
        Dready = 1'b0;
        Cnt0   = '0;
        Cnt1   = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_dout", Dout, 8'h00);
        check("rst_dvalid", Dvalid, 1'b0);
        check("rst_dlast", Dlast, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_drop", Drop, 1'b0);
        Reset = 1'b1;

        // plain frame, sink always ready
        step(1'b1, 1'b1, 64'h0102030405060708, 64'h1112131415161718);
        drain(40);

        // all-ones counters
        step(1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
        drain(40);

        // sink ready toggling each cycle
        step(1'b1, 1'b0, 64'h0102030405060708, 64'h1112131415161718);
        for (int i = 0; i < 40; i++) step(1'b0, i[0], 64'h0, 64'h0);
        drain(40);

        // counter keeps moving after capture
        c0 = 64'd5;
        step(1'b1, 1'b1, c0, 64'h0);
        for (int i = 0; i < 20; i++) begin
            c0 = c0 + 1;
            step(1'b0, 1'b1, c0, 64'h0);
        end
        drain(40);

        // snaps while busy: mid frame and on the checksum transfer edge
        step(1'b1, 1'b1, 64'hDEADBEEF00C0FFEE, 64'h0123456789ABCDEF);
        for (int i = 1; i < 22; i++)
            step((i == 4) || (i == 18), 1'b1, 64'h5555, 64'hAAAA);
        drain(40);

        // reset mid-frame
        step(1'b1, 1'b1, 64'h1111111111111111, 64'h2222222222222222);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 64'h0, 64'h0);
        @(posedge Clk);
        #1;
        Snap  = 1'b0;
        Reset = 1'b0;
        #1;
        check("async_dvalid", Dvalid, 1'b0);
        check("async_busy", Busy, 1'b0);
        check("async_dlast", Dlast, 1'b0);
        check("async_dout", Dout, 8'h00);
        m_active = 0;
        m_rem    = 0;
        m_drop   = 0;
        exp_q.delete();
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 64'h0, 64'h0);
        step(1'b1, 1'b1, 64'h0A0B0C0D0E0F1011, 64'hFEDCBA9876543210);
        drain(40);

        // randomized traffic
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(7) == 0), ($urandom_range(3) != 0),
                 {$urandom, $urandom}, {$urandom, $urandom});
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
